// File: rtl/control_puertas_pkg.sv
// Shared types and helpers for the elevator door controller.
// Door FSM state encoding, motion-controller state codes, one-hot check.
// No logic of its own; imported by the controller and its timer user.
package control_puertas_pkg;

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABIERTA  = 2'b01,
    CERRANDO = 2'b10
  } estado_puerta_t;

  localparam logic [1:0] ESTADO_DETENIDO = 2'b00;
  localparam logic [1:0] ESTADO_SUBIENDO = 2'b01;
  localparam logic [1:0] ESTADO_BAJANDO  = 2'b10;
  localparam logic [1:0] ESTADO_FALLA    = 2'b11;

  // Widest per-floor vector the one-hot helper accepts.
  localparam int MAX_PISOS = 32;

  // True when exactly one bit is set.
  function automatic logic es_onehot(input logic [MAX_PISOS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/temporizador_puerta.sv
// Loadable down-counter with zero flag, used as the door-hold timer.
// Load has priority over decrement; counter stops at zero.
// Zero flag is decoded directly from the count register.
module temporizador_puerta #(
  parameter int ANCHO = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor,
  input  logic             decrementar,
  output logic             cero
);

  logic [ANCHO-1:0] cuenta;

  // Count register: reset clears, load wins over decrement, no wrap below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= valor;
    end else if (decrementar && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign cero = (cuenta == '0);

endmodule

// File: rtl/control_puertas.sv
// Door controller for one elevator car: opens, holds, closes and reopens the door.
// All outputs registered; a request at edge k shows the door command at cycle k+1.
// Door safety (sensor/button reopen) overrides motion state and floor inputs.
module control_puertas
  import control_puertas_pkg::*;
#(
  parameter int N_PISOS   = 4,
  parameter int T_ABIERTA = 20,
  parameter int T_AVISO   = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PISOS-1:0] pisos,
  input  logic [1:0]         estado,
  input  logic               boton,
  input  logic [N_PISOS-1:0] botones,
  input  logic [N_PISOS-1:0] puertas,
  input  logic               sensor,
  output logic               timeout,
  output logic               aviso,
  output logic [N_PISOS-1:0] salida_puertas,
  output logic               trabajando
);

  localparam int ANCHO_T = $clog2(T_ABIERTA);
  localparam int ANCHO_O = $clog2(T_AVISO + 1);
  localparam logic [ANCHO_T-1:0] CARGA_HOLD = ANCHO_T'(T_ABIERTA - 1);
  localparam logic [ANCHO_O-1:0] OBS_MAX    = ANCHO_O'(T_AVISO);

  estado_puerta_t     st, st_n;
  logic [N_PISOS-1:0] piso_lat, piso_lat_n;
  logic [N_PISOS-1:0] salida_n;
  logic               trabajando_n, timeout_n, aviso_n;
  logic [ANCHO_O-1:0] obs, obs_n;

  logic cargar, decrementar, cero;
  logic piso_valido, pedido, recarga;

  // A floor counts only when the car is level with exactly one floor.
  assign piso_valido = es_onehot(MAX_PISOS'(pisos));
  assign pedido      = boton || ((botones & pisos) != '0);
  // Anything that keeps the door open restarts the hold time.
  assign recarga     = sensor || boton || ((botones & piso_lat) != '0);

  temporizador_puerta #(
    .ANCHO(ANCHO_T)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .cargar     (cargar),
    .valor      (CARGA_HOLD),
    .decrementar(decrementar),
    .cero       (cero)
  );

  // State, latched floor and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= CERRADA;
      piso_lat       <= '0;
      salida_puertas <= '0;
      trabajando     <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      st             <= st_n;
      piso_lat       <= piso_lat_n;
      salida_puertas <= salida_n;
      trabajando     <= trabajando_n;
      timeout        <= timeout_n;
    end
  end

  // Next state, next outputs and hold-timer control.
  always_comb begin
    st_n         = st;
    piso_lat_n   = piso_lat;
    salida_n     = '0;
    trabajando_n = 1'b0;
    timeout_n    = 1'b0;
    cargar       = 1'b0;
    decrementar  = 1'b0;
    case (st)
      CERRADA: begin
        if ((estado == ESTADO_DETENIDO) && piso_valido && pedido) begin
          st_n         = ABIERTA;
          piso_lat_n   = pisos;
          salida_n     = pisos;
          trabajando_n = 1'b1;
          cargar       = 1'b1;
        end
      end
      ABIERTA: begin
        trabajando_n = 1'b1;
        if (recarga) begin
          salida_n = piso_lat;
          cargar   = 1'b1;
        end else if (cero) begin
          st_n      = CERRANDO;
          timeout_n = 1'b1;
        end else begin
          salida_n    = piso_lat;
          decrementar = 1'b1;
        end
      end
      CERRANDO: begin
        trabajando_n = 1'b1;
        // Reopen is checked before the closed switch on purpose.
        if (sensor || boton) begin
          st_n     = ABIERTA;
          salida_n = piso_lat;
          cargar   = 1'b1;
        end else if ((puertas & piso_lat) != '0) begin
          st_n         = CERRADA;
          trabajando_n = 1'b0;
        end
      end
      default: begin
        st_n = CERRADA;
      end
    endcase
  end

  // Obstruction counter and warning: saturating count of consecutive obstructed cycles.
  always_comb begin
    obs_n   = '0;
    aviso_n = 1'b0;
    if ((st != CERRADA) && sensor) begin
      obs_n   = (obs == OBS_MAX) ? obs : obs + 1'b1;
      aviso_n = (obs == OBS_MAX);
    end
  end

  // Obstruction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      obs   <= '0;
      aviso <= 1'b0;
    end else begin
      obs   <= obs_n;
      aviso <= aviso_n;
    end
  end

endmodule

// File: tb/tb_control_puertas.sv
// Directed bench for control_puertas: vector table plus multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_control_puertas;

  localparam int N  = 4;
  localparam int TA = 20;
  localparam int TV = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pisos, botones, puertas, salida_puertas;
  logic [1:0]   estado;
  logic         boton, sensor, timeout, aviso, trabajando;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_puertas #(
    .N_PISOS  (N),
    .T_ABIERTA(TA),
    .T_AVISO  (TV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pisos         (pisos),
    .estado        (estado),
    .boton         (boton),
    .botones       (botones),
    .puertas       (puertas),
    .sensor        (sensor),
    .timeout       (timeout),
    .aviso         (aviso),
    .salida_puertas(salida_puertas),
    .trabajando    (trabajando)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   est;
    logic [N-1:0] pis;
    logic         bot;
    logic [N-1:0] bots;
    logic [N-1:0] pue;
    logic         sen;
    logic [N-1:0] e_sal;
    logic         e_trab;
    logic         e_to;
    logic         e_av;
  } vec_t;

  vec_t tabla[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] est, input logic [N-1:0] pis,
                              input logic bot, input logic [N-1:0] bots,
                              input logic [N-1:0] e_sal, input logic e_trab);
    vec_t v;
    v.rst = rst; v.est = est; v.pis = pis; v.bot = bot; v.bots = bots;
    v.pue = '0; v.sen = 1'b0;
    v.e_sal = e_sal; v.e_trab = e_trab; v.e_to = 1'b0; v.e_av = 1'b0;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] e_sal,
                     input logic e_trab, input logic e_to, input logic e_av);
    n_tests++;
    if (salida_puertas !== e_sal || trabajando !== e_trab || timeout !== e_to || aviso !== e_av) begin
      n_fail++;
      $display("FAIL %s: got sal=%b trab=%b to=%b av=%b, expected sal=%b trab=%b to=%b av=%b",
               name, salida_puertas, trabajando, timeout, aviso, e_sal, e_trab, e_to, e_av);
    end
  endtask

  // Door already open at floor p for one cycle: hold the rest, then expect the timeout pulse.
  task automatic hold_close(input string name, input logic [N-1:0] p);
    for (int j = 1; j < TA; j++) begin
      tick;
      chk(name, p, 1'b1, 1'b0, 1'b0);
    end
    tick;
    chk({name, "_timeout"}, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; estado = 2'b00; pisos = 4'b0010; boton = 1'b0;
    botones = '0; puertas = '0; sensor = 1'b0;

    // Reset, idle, ignored requests, then a valid hall call.
    tabla.push_back(mk(1'b1, 2'b00, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0));
    for (int i = 0; i < 10; i++)
      tabla.push_back(mk(1'b0, 2'b00, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b01, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b10, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b11, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b00, 4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b00, 4'b0010, 1'b0, 4'b0100, 4'b0000, 1'b0));
    tabla.push_back(mk(1'b0, 2'b00, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1));

    foreach (tabla[i]) begin
      reset = tabla[i].rst; estado = tabla[i].est; pisos = tabla[i].pis;
      boton = tabla[i].bot; botones = tabla[i].bots; puertas = tabla[i].pue;
      sensor = tabla[i].sen;
      tick;
      chk($sformatf("tabla[%0d]", i), tabla[i].e_sal, tabla[i].e_trab, tabla[i].e_to, tabla[i].e_av);
    end

    // Uninterrupted open: cycles k+1..k+20 open, timeout at k+21, close at k+24.
    botones = '0;
    for (int j = 2; j <= TA; j++) begin
      tick;
      chk("hold1", 4'b0010, 1'b1, 1'b0, 1'b0);
      // Motion state and position must not matter once the door is in use.
      if (j == 9) begin
        estado = 2'b01;
        pisos  = 4'b0100;
      end
    end
    tick;
    chk("timeout1", '0, 1'b1, 1'b1, 1'b0);
    tick;
    chk("cerrando1", '0, 1'b1, 1'b0, 1'b0);
    estado = 2'b00;
    pisos  = 4'b0010;
    tick;
    chk("cerrando2", '0, 1'b1, 1'b0, 1'b0);
    puertas = 4'b0010;
    tick;
    chk("cerrada1", '0, 1'b0, 1'b0, 1'b0);
    tick;
    chk("cerrada1b", '0, 1'b0, 1'b0, 1'b0);

    // Reopen from CERRANDO; sensor wins over the closed switch.
    puertas = '0;
    boton = 1'b1;
    tick;
    chk("open2", 4'b0010, 1'b1, 1'b0, 1'b0);
    boton = 1'b0;
    hold_close("hold2", 4'b0010);
    sensor  = 1'b1;
    puertas = 4'b0010;
    tick;
    chk("reopen", 4'b0010, 1'b1, 1'b0, 1'b0);
    sensor  = 1'b0;
    puertas = '0;
    hold_close("hold3", 4'b0010);
    puertas = 4'b0010;
    tick;
    chk("cerrada2", '0, 1'b0, 1'b0, 1'b0);

    // Prolonged obstruction: aviso from 51 cycles after sensor rises.
    puertas = '0;
    boton = 1'b1;
    tick;
    chk("open3", 4'b0010, 1'b1, 1'b0, 1'b0);
    boton = 1'b0;
    tick;
    chk("open3b", 4'b0010, 1'b1, 1'b0, 1'b0);
    sensor = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      tick;
      chk($sformatf("obstr%0d", j), 4'b0010, 1'b1, 1'b0, (j >= TV + 1) ? 1'b1 : 1'b0);
    end
    sensor = 1'b0;
    tick;
    chk("aviso_drop", 4'b0010, 1'b1, 1'b0, 1'b0);

    // Reset while open drops everything at once.
    reset = 1'b1;
    tick;
    chk("reset_mid", '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick;
    chk("post_reset", '0, 1'b0, 1'b0, 1'b0);

    // Fresh request at another floor after reset.
    pisos   = 4'b0001;
    botones = 4'b0001;
    tick;
    chk("open4", 4'b0001, 1'b1, 1'b0, 1'b0);
    botones = '0;
    hold_close("hold4", 4'b0001);
    puertas = 4'b0001;
    tick;
    chk("cerrada4", '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
